// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory request/response bus between the fetch stage and
// instruction memory. Single outstanding request, in-order responses.
//
//   imemAddr   : request address (fetch PC)
//   imemReq    : request valid
//   imemGnt    : request accepted when imemReq & imemGnt
//   imemRdata  : response instruction word
//   imemRvalid : response valid, at least one cycle after the grant
//
// master modport : fetch stage side
// slave modport  : instruction memory side
// ---------------------------------------------------------------------------
interface fetch_stage_if;
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] imemAddr;
  logic            imemReq;
  logic            imemGnt;
  logic [XLEN-1:0] imemRdata;
  logic            imemRvalid;

  modport master (
    output imemAddr,
    output imemReq,
    input  imemGnt,
    input  imemRdata,
    input  imemRvalid
  );

  modport slave (
    input  imemAddr,
    input  imemReq,
    output imemGnt,
    output imemRdata,
    output imemRvalid
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage. Owns the fetch PC, selects the next PC from
// execute-stage redirects, runs a single-outstanding req/gnt/rvalid
// handshake to instruction memory, parks one response in a hold buffer
// when decode cannot take it, and drives the IF/ID pipeline register.
//
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   stall_IF      : blocks new fetch requests, holds the PC
//   stall_ID      : holds the IF/ID register
//   flush_ID      : loads a bubble into IF/ID
//   PCNextSrc_EX  : 00 seq, 01 branch/jal, 10 jalr, 11 seq
//   PCTarget_EX   : branch/jal target
//   ALUResult_EX  : jalr target
//   imem          : instruction memory bus (master side)
//   instr_ID      : IF/ID instruction
//   PC_ID         : IF/ID PC
//   PCPlus4_ID    : IF/ID PC+4
//   valid_ID      : IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_IF,
  input  logic                stall_ID,
  input  logic                flush_ID,
  input  logic [1:0]          PCNextSrc_EX,
  input  logic [31:0]         PCTarget_EX,
  input  logic [31:0]         ALUResult_EX,
  fetch_stage_if.master       imem,
  output logic [31:0]         instr_ID,
  output logic [31:0]         PC_ID,
  output logic [31:0]         PCPlus4_ID,
  output logic                valid_ID
);

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetchState_t;

  fetchState_t     state;
  fetchState_t     stateNext;

  logic [XLEN-1:0] pcF;
  logic [XLEN-1:0] pcReq;
  logic            bufValid;
  logic [XLEN-1:0] bufInstr;
  logic [XLEN-1:0] bufPC;

  logic            redirect;
  logic [XLEN-1:0] targetSel;
  logic [XLEN-1:0] target;
  logic            issueOk;
  logic            liveResp;
  logic            deliverDirect;
  logic            req;
  logic            granted;

  // Redirect decode; targets are forced word-aligned.
  assign redirect  = (PCNextSrc_EX == 2'b01) || (PCNextSrc_EX == 2'b10);
  assign targetSel = (PCNextSrc_EX == 2'b01) ? PCTarget_EX : ALUResult_EX;
  assign target    = {targetSel[XLEN-1:2], 2'b00};

  // A new request may go out only when nothing is parked and no redirect is
  // pending; rst gates it so the bus is quiet while reset is held.
  assign issueOk = ~redirect & ~stall_IF & ~bufValid & ~rst;

  // Response belongs to the current path and is consumed this cycle.
  assign liveResp      = (state == WAIT) & imem.imemRvalid & ~redirect;
  assign deliverDirect = liveResp & ~stall_ID & ~flush_ID;

  assign granted       = req & imem.imemGnt;
  assign imem.imemReq  = req;
  assign imem.imemAddr = pcF;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and request logic.
  always_comb begin
    stateNext = state;
    req       = 1'b0;
    unique case (state)
      FETCH: begin
        req = issueOk;
        if (req && imem.imemGnt) begin
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (imem.imemRvalid) begin
          if (redirect) begin
            stateNext = FETCH;
          end else begin
            // Back-to-back issue only when the response bypasses the buffer.
            req       = issueOk & deliverDirect;
            stateNext = (req && imem.imemGnt) ? WAIT : FETCH;
          end
        end else if (redirect) begin
          stateNext = DISCARD;
        end
      end
      DISCARD: begin
        if (imem.imemRvalid) begin
          stateNext = FETCH;
        end
      end
      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  // Fetch PC and outstanding-request address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcF   <= RESET_PC;
      pcReq <= RESET_PC;
    end else begin
      if (redirect) begin
        pcF <= target;
      end else if (granted) begin
        pcF <= pcF + XLEN'(INSTR_BYTES);
      end
      if (granted) begin
        pcReq <= pcF;
      end
    end
  end

  // One-entry hold buffer for responses decode could not accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bufValid <= 1'b0;
      bufInstr <= NOP_INSTR;
      bufPC    <= '0;
    end else begin
      if (redirect) begin
        bufValid <= 1'b0;
      end else if (liveResp && (stall_ID || flush_ID)) begin
        bufValid <= 1'b1;
        bufInstr <= imem.imemRdata;
        bufPC    <= pcReq;
      end else if (bufValid && !stall_ID && !flush_ID) begin
        bufValid <= 1'b0;
      end
    end
  end

  // IF/ID pipeline register: flush, hold, buffer, live response, bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_ID   <= NOP_INSTR;
      PC_ID      <= '0;
      PCPlus4_ID <= '0;
      valid_ID   <= 1'b0;
    end else if (flush_ID) begin
      instr_ID   <= NOP_INSTR;
      PC_ID      <= '0;
      PCPlus4_ID <= '0;
      valid_ID   <= 1'b0;
    end else if (stall_ID) begin
      instr_ID   <= instr_ID;
      PC_ID      <= PC_ID;
      PCPlus4_ID <= PCPlus4_ID;
      valid_ID   <= valid_ID;
    end else if (bufValid) begin
      instr_ID   <= bufInstr;
      PC_ID      <= bufPC;
      PCPlus4_ID <= bufPC + XLEN'(INSTR_BYTES);
      valid_ID   <= 1'b1;
    end else if (liveResp) begin
      instr_ID   <= imem.imemRdata;
      PC_ID      <= pcReq;
      PCPlus4_ID <= pcReq + XLEN'(INSTR_BYTES);
      valid_ID   <= 1'b1;
    end else begin
      instr_ID   <= NOP_INSTR;
      PC_ID      <= '0;
      PCPlus4_ID <= '0;
      valid_ID   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Randomized bench for fetch_stage. A latency-randomized instruction memory
// answers granted requests; a transaction-level reference model (queue of
// outstanding request PCs tagged stale/live, a hold buffer, the IF/ID
// contents) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0100;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall_IF;
  logic        stall_ID;
  logic        flush_ID;
  logic [1:0]  PCNextSrc_EX;
  logic [31:0] PCTarget_EX;
  logic [31:0] ALUResult_EX;
  logic [31:0] instr_ID;
  logic [31:0] PC_ID;
  logic [31:0] PCPlus4_ID;
  logic        valid_ID;

  fetch_stage_if imem ();

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_IF     (stall_IF),
    .stall_ID     (stall_ID),
    .flush_ID     (flush_ID),
    .PCNextSrc_EX (PCNextSrc_EX),
    .PCTarget_EX  (PCTarget_EX),
    .ALUResult_EX (ALUResult_EX),
    .imem         (imem),
    .instr_ID     (instr_ID),
    .PC_ID        (PC_ID),
    .PCPlus4_ID   (PCPlus4_ID),
    .valid_ID     (valid_ID)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } outEntry_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memEntry_t;

  // Reference model state
  outEntry_t   mOut[$];
  logic [31:0] mPcF;
  bit          mBufValid;
  logic [31:0] mBufInstr;
  logic [31:0] mBufPc;
  logic [31:0] mInstr;
  logic [31:0] mPc;
  logic [31:0] mPc4;
  bit          mValid;

  // Memory model state
  memEntry_t   pend[$];

  int vecCnt  = 0;
  int errCnt  = 0;
  int cycle   = 0;
  int mode    = 0;
  bit holdRst = 1'b1;
  bit curWait = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s cycle=%0d got=%08h exp=%08h", tag, cycle, got, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    logic [31:0] h;
    h = addr * 32'h9E37_79B1;
    return h ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] pickTarget();
    logic [31:0] t;
    case ($urandom % 6)
      0:       t = 32'h0000_0200;
      1:       t = 32'h0000_0203;
      2:       t = 32'hFFFF_FFF0 | 32'($urandom % 16);
      default: t = $urandom;
    endcase
    return t;
  endfunction

  task automatic modelReset();
    mOut.delete();
    mPcF      = RESET_PC;
    mBufValid = 1'b0;
    mBufInstr = NOP_INSTR;
    mBufPc    = '0;
    mInstr    = NOP_INSTR;
    mPc       = '0;
    mPc4      = '0;
    mValid    = 1'b0;
  endtask

  task automatic bubble();
    mInstr = NOP_INSTR;
    mPc    = '0;
    mPc4   = '0;
    mValid = 1'b0;
  endtask

  task automatic doCycle();
    bit          redir;
    bit          resp;
    bit          live;
    bit          direct;
    bit          issue;
    logic [31:0] tgt;
    logic [31:0] rdata;
    int          r;
    int          k;

    @(posedge clk);
    #1;
    cycle++;
    rst = holdRst;

    // Hazard unit / execute stage stimulus
    if (mode == 0) begin
      stall_IF     = 1'b0;
      stall_ID     = 1'b0;
      flush_ID     = 1'b0;
      PCNextSrc_EX = 2'b00;
      PCTarget_EX  = $urandom;
      ALUResult_EX = $urandom;
    end else begin
      stall_IF     = ($urandom % 100) < 15;
      stall_ID     = ($urandom % 100) < 20;
      r            = int'($urandom % 100);
      PCNextSrc_EX = (r < 8) ? 2'b01 : (r < 16) ? 2'b10 : (r < 20) ? 2'b11 : 2'b00;
      PCTarget_EX  = pickTarget();
      ALUResult_EX = pickTarget();
      flush_ID     = (PCNextSrc_EX == 2'b01) || (PCNextSrc_EX == 2'b10) || (($urandom % 100) < 8);
    end

    // Memory: answer in order once the latency has elapsed
    if (pend.size() > 0 && cycle >= pend[0].due) begin
      imem.imemRvalid = 1'b1;
      imem.imemRdata  = memWord(pend[0].addr);
    end else begin
      imem.imemRvalid = 1'b0;
      imem.imemRdata  = $urandom;
    end
    imem.imemGnt = (pend.size() == 0 || imem.imemRvalid) && (mode == 0 || ($urandom % 4) != 0);
    #1;

    // Reference model: what should happen this cycle
    redir  = (PCNextSrc_EX == 2'b01) || (PCNextSrc_EX == 2'b10);
    tgt    = (PCNextSrc_EX == 2'b01) ? PCTarget_EX : ALUResult_EX;
    tgt    = tgt & 32'hFFFF_FFFC;
    rdata  = imem.imemRdata;
    resp   = imem.imemRvalid && mOut.size() > 0;
    live   = resp && !mOut[0].stale && !redir;
    direct = live && !stall_ID && !flush_ID;
    issue  = !rst && !redir && !stall_IF && !mBufValid && (mOut.size() == 0 || direct);
    curWait = (mOut.size() == 1) && !mOut[0].stale;

    checkVal("imemReq",    32'(imem.imemReq), 32'(issue));
    checkVal("imemAddr",   imem.imemAddr, mPcF);
    checkVal("instr_ID",   instr_ID, mInstr);
    checkVal("PC_ID",      PC_ID, mPc);
    checkVal("PCPlus4_ID", PCPlus4_ID, mPc4);
    checkVal("valid_ID",   32'(valid_ID), 32'(mValid));

    // Memory bookkeeping follows what the DUT actually did
    if (imem.imemRvalid) void'(pend.pop_front());
    if (imem.imemReq && imem.imemGnt) begin
      k = (mode == 0) ? 1 : int'($urandom_range(1, 3));
      pend.push_back('{imem.imemAddr, cycle + k});
    end

    // Reference model: state after the coming edge
    if (rst) begin
      modelReset();
    end else begin
      if (flush_ID) begin
        bubble();
      end else if (stall_ID) begin
        // hold
      end else if (mBufValid) begin
        mInstr    = mBufInstr;
        mPc       = mBufPc;
        mPc4      = mBufPc + 32'd4;
        mValid    = 1'b1;
        mBufValid = 1'b0;
      end else if (live) begin
        mInstr = rdata;
        mPc    = mOut[0].pc;
        mPc4   = mOut[0].pc + 32'd4;
        mValid = 1'b1;
      end else begin
        bubble();
      end

      if (redir) begin
        mBufValid = 1'b0;
      end else if (live && (stall_ID || flush_ID)) begin
        mBufValid = 1'b1;
        mBufInstr = rdata;
        mBufPc    = mOut[0].pc;
      end

      if (resp) void'(mOut.pop_front());
      if (redir && mOut.size() > 0) mOut[0].stale = 1'b1;
      if (issue && imem.imemGnt) mOut.push_back('{mPcF, 1'b0});

      if (redir) mPcF = tgt;
      else if (issue && imem.imemGnt) mPcF = mPcF + 32'd4;
    end
  endtask

  initial begin
    bit found;
    rst             = 1'b1;
    stall_IF        = 1'b0;
    stall_ID        = 1'b0;
    flush_ID        = 1'b0;
    PCNextSrc_EX    = 2'b00;
    PCTarget_EX     = '0;
    ALUResult_EX    = '0;
    imem.imemGnt    = 1'b0;
    imem.imemRdata  = '0;
    imem.imemRvalid = 1'b0;
    modelReset();

    // Reset held, then clean streaming with a k=1 always-grant memory
    mode = 0;
    repeat (2) doCycle();
    holdRst = 1'b0;
    repeat (40) doCycle();

    // Full random hazards, redirects, latencies and grant gaps
    mode = 1;
    repeat (1500) doCycle();

    // Asynchronous reset while a live request is outstanding
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      doCycle();
      if (curWait) found = 1'b1;
    end
    checkVal("waitFound", 32'(found), 32'd1);
    #2;
    rst     = 1'b1;
    holdRst = 1'b1;
    #1;
    checkVal("rstReq",     32'(imem.imemReq), 32'd0);
    checkVal("rstAddr",    imem.imemAddr, RESET_PC);
    checkVal("rstInstr",   instr_ID, NOP_INSTR);
    checkVal("rstPC",      PC_ID, 32'd0);
    checkVal("rstPCPlus4", PCPlus4_ID, 32'd0);
    checkVal("rstValid",   32'(valid_ID), 32'd0);
    modelReset();
    // The pre-reset response lands in the first cycle after release
    if (pend.size() > 0) pend[0].due = cycle + 2;
    doCycle();
    holdRst = 1'b0;
    repeat (1500) doCycle();

    mode = 0;
    repeat (40) doCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
